// File: rtl/ct_had_xtrig_ctrl_pkg.sv
// Shared types and defaults for the cluster debug cross-trigger controller.
// Optional feature macro: CT_HAD_XTRIG_TIMEOUT_EN (broadcast timeout).
package ct_had_xtrig_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_HALT   = 2'b01,
      ST_RESUME = 2'b10
   } xtrig_state_e;

   localparam int unsigned TO_W_DEF      = 10;
   localparam int unsigned TO_CYCLES_DEF = 1000;

endpackage

// File: rtl/ct_had_xtrig_ctrl_if.sv
// Per-core request/status bundle between the HAD event blocks and the
// cross-trigger controller. master = core/cluster side, slave = controller.
interface ct_had_xtrig_ctrl_if #(
   parameter int unsigned NUM_CORE = 4
);
   logic [NUM_CORE-1:0] core_enter_req;
   logic [NUM_CORE-1:0] core_exit_req;
   logic [NUM_CORE-1:0] core_dbgon;
   logic [NUM_CORE-1:0] regs_halt_grp;
   logic [NUM_CORE-1:0] regs_resume_grp;
   logic [NUM_CORE-1:0] xtrig_enter_dbg;
   logic [NUM_CORE-1:0] xtrig_exit_dbg;
   logic                xtrig_busy;
   logic                xtrig_timeout;
   logic                xtrig_clk_en;

   modport master (
      output core_enter_req, core_exit_req, core_dbgon,
             regs_halt_grp, regs_resume_grp,
      input  xtrig_enter_dbg, xtrig_exit_dbg, xtrig_busy,
             xtrig_timeout, xtrig_clk_en
   );

   modport slave (
      input  core_enter_req, core_exit_req, core_dbgon,
             regs_halt_grp, regs_resume_grp,
      output xtrig_enter_dbg, xtrig_exit_dbg, xtrig_busy,
             xtrig_timeout, xtrig_clk_en
   );
endinterface

// File: rtl/ct_had_xtrig_tmr.sv
// Broadcast timeout counter: cleared while idle, counts busy cycles and
// flags the terminal count (TO_CYCLES-1). Built only with
// CT_HAD_XTRIG_TIMEOUT_EN defined.
module ct_had_xtrig_tmr
   import ct_had_xtrig_ctrl_pkg::*;
#(
   parameter int unsigned TO_W      = TO_W_DEF,
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic cpuclk,
   input  logic cpurst_b,
   input  logic clr,
   input  logic en,
   output logic tc
);

   logic [TO_W-1:0] cnt;

   assign tc = en && (cnt == TO_W'(TO_CYCLES - 1));

   // Count busy cycles, holding at terminal count until the FSM leaves
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !tc) begin
         cnt <= cnt + TO_W'(1);
      end
   end

endmodule

// File: rtl/ct_had_xtrig_ctrl.sv
// Cluster debug cross-trigger controller: sequences group halt / group
// resume broadcasts across the cores selected by the group masks.
// Optional feature macro: CT_HAD_XTRIG_TIMEOUT_EN (aborts a broadcast
// after TO_CYCLES busy cycles and pulses xtrig_timeout).
module ct_had_xtrig_ctrl
   import ct_had_xtrig_ctrl_pkg::*;
#(
   parameter int unsigned NUM_CORE  = 4,
   parameter int unsigned TO_W      = TO_W_DEF,
   parameter int unsigned TO_CYCLES = TO_CYCLES_DEF
) (
   input  logic                cpuclk,
   input  logic                cpurst_b,
   ct_had_xtrig_ctrl_if.slave  xbus
);

   if ((NUM_CORE < 1) || (NUM_CORE > 8) || (TO_CYCLES > (2**TO_W) - 1)) begin : g_bad_cfg
      $error("ct_had_xtrig_ctrl: NUM_CORE out of 1..8 or TO_CYCLES does not fit TO_W");
   end

   xtrig_state_e        state;
   logic [NUM_CORE-1:0] tgt;
   logic [NUM_CORE-1:0] enter_dbg;
   logic [NUM_CORE-1:0] exit_dbg;
   logic                pend_halt;
   logic                halt_trig;
   logic                resume_trig;
   logic                to_hit;
   logic [NUM_CORE-1:0] halt_left;
   logic [NUM_CORE-1:0] resume_left;
   logic [NUM_CORE-1:0] halt_entry_tgt;
   logic [NUM_CORE-1:0] resume_entry_tgt;

   assign halt_trig        = |(xbus.core_enter_req & xbus.regs_halt_grp);
   assign resume_trig      = |(xbus.core_exit_req & xbus.regs_resume_grp);
   assign halt_left        = tgt & ~xbus.core_dbgon;
   assign resume_left      = tgt & xbus.core_dbgon;
   assign halt_entry_tgt   = xbus.regs_halt_grp & ~xbus.core_dbgon;
   assign resume_entry_tgt = xbus.regs_resume_grp & xbus.core_dbgon;

`ifdef CT_HAD_XTRIG_TIMEOUT_EN
   // Every broadcast is entered from IDLE, so clearing while idle gives a
   // zero count on the first busy cycle.
   ct_had_xtrig_tmr #(
      .TO_W      (TO_W),
      .TO_CYCLES (TO_CYCLES)
   ) u_tmr (
      .cpuclk   (cpuclk),
      .cpurst_b (cpurst_b),
      .clr      (state == ST_IDLE),
      .en       (state != ST_IDLE),
      .tc       (to_hit)
   );
`else
   assign to_hit = 1'b0;
`endif

   // Broadcast sequencer: latch targets on entry, retire cores as they respond
   always_ff @(posedge cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state     <= ST_IDLE;
         tgt       <= '0;
         enter_dbg <= '0;
         exit_dbg  <= '0;
         pend_halt <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (halt_trig || pend_halt) begin
                  state     <= ST_HALT;
                  tgt       <= halt_entry_tgt;
                  enter_dbg <= halt_entry_tgt;
                  pend_halt <= 1'b0;
               end else if (resume_trig) begin
                  state    <= ST_RESUME;
                  tgt      <= resume_entry_tgt;
                  exit_dbg <= resume_entry_tgt;
               end
            end
            ST_HALT: begin
               if (to_hit || (halt_left == '0)) begin
                  state     <= ST_IDLE;
                  tgt       <= '0;
                  enter_dbg <= '0;
               end else begin
                  tgt       <= halt_left;
                  enter_dbg <= halt_left;
               end
            end
            ST_RESUME: begin
               if (halt_trig) begin
                  pend_halt <= 1'b1;
               end
               if (to_hit || (resume_left == '0)) begin
                  state    <= ST_IDLE;
                  tgt      <= '0;
                  exit_dbg <= '0;
               end else begin
                  tgt      <= resume_left;
                  exit_dbg <= resume_left;
               end
            end
            default: begin
               state     <= ST_IDLE;
               tgt       <= '0;
               enter_dbg <= '0;
               exit_dbg  <= '0;
            end
         endcase
      end
   end

   assign xbus.xtrig_enter_dbg = enter_dbg;
   assign xbus.xtrig_exit_dbg  = exit_dbg;
   assign xbus.xtrig_busy      = (state != ST_IDLE);
   assign xbus.xtrig_timeout   = to_hit;
   assign xbus.xtrig_clk_en    = (state != ST_IDLE) | (|xbus.core_enter_req) |
                                 (|xbus.core_exit_req);

endmodule

// File: tb/tb_ct_had_xtrig_ctrl.sv
// Directed bench for ct_had_xtrig_ctrl (NUM_CORE=4, TO_CYCLES=16).
// Timeout expectations follow CT_HAD_XTRIG_TIMEOUT_EN.
module tb_ct_had_xtrig_ctrl;

   logic cpuclk;
   logic cpurst_b;
   int   n_vec;
   int   n_err;
   int   first_to;
   int   to_cnt;

   ct_had_xtrig_ctrl_if #(.NUM_CORE(4)) xbus ();

   ct_had_xtrig_ctrl #(
      .NUM_CORE  (4),
      .TO_W      (10),
      .TO_CYCLES (16)
   ) dut (
      .cpuclk   (cpuclk),
      .cpurst_b (cpurst_b),
      .xbus     (xbus)
   );

   initial cpuclk = 1'b0;
   always #5 cpuclk = ~cpuclk;

   task automatic step();
      @(posedge cpuclk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      cpurst_b             = 1'b0;
      xbus.core_enter_req  = '0;
      xbus.core_exit_req   = '0;
      xbus.core_dbgon      = '0;
      xbus.regs_halt_grp   = '0;
      xbus.regs_resume_grp = '0;
      #1;
      chk4("rst_enter", xbus.xtrig_enter_dbg, 4'b0000);
      chk4("rst_exit", xbus.xtrig_exit_dbg, 4'b0000);
      chk1("rst_busy", xbus.xtrig_busy, 1'b0);
      chk1("rst_timeout", xbus.xtrig_timeout, 1'b0);
      chk1("rst_clk_en", xbus.xtrig_clk_en, 1'b0);
      step();
      step();
      cpurst_b = 1'b1;
      step();

      // group halt
      xbus.regs_halt_grp  = 4'b1011;
      xbus.core_enter_req = 4'b0001;
      #1;
      chk1("clk_en_req", xbus.xtrig_clk_en, 1'b1);
      step();
      xbus.core_enter_req = '0;
      chk4("halt_enter_p1", xbus.xtrig_enter_dbg, 4'b1011);
      chk1("halt_busy_p1", xbus.xtrig_busy, 1'b1);
      chk1("halt_clk_en", xbus.xtrig_clk_en, 1'b1);
      step();
      chk4("halt_enter_p2", xbus.xtrig_enter_dbg, 4'b1011);
      step();
      xbus.core_dbgon = 4'b0010;
      chk4("halt_enter_p3", xbus.xtrig_enter_dbg, 4'b1011);
      step();
      chk4("halt_enter_p4", xbus.xtrig_enter_dbg, 4'b1001);
      chk4("halt_exit_p4", xbus.xtrig_exit_dbg, 4'b0000);
      xbus.core_dbgon = 4'b1011;
      step();
      chk4("halt_enter_done", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("halt_busy_done", xbus.xtrig_busy, 1'b0);

      // group resume
      xbus.regs_resume_grp = 4'b0110;
      xbus.core_dbgon      = 4'b0111;
      xbus.core_exit_req   = 4'b0100;
      step();
      xbus.core_exit_req = '0;
      chk4("res_exit", xbus.xtrig_exit_dbg, 4'b0110);
      chk4("res_enter", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("res_busy", xbus.xtrig_busy, 1'b1);
      xbus.core_dbgon = 4'b0001;
      step();
      chk4("res_exit_done", xbus.xtrig_exit_dbg, 4'b0000);
      chk1("res_busy_done", xbus.xtrig_busy, 1'b0);

      // simultaneous enter/exit: halt wins, exit dropped
      xbus.core_dbgon     = 4'b0000;
      xbus.core_enter_req = 4'b0001;
      xbus.core_exit_req  = 4'b0010;
      step();
      xbus.core_enter_req = '0;
      xbus.core_exit_req  = '0;
      chk4("sim_enter", xbus.xtrig_enter_dbg, 4'b1011);
      chk4("sim_exit", xbus.xtrig_exit_dbg, 4'b0000);
      xbus.core_dbgon = 4'b1011;
      step();
      chk1("sim_busy_done", xbus.xtrig_busy, 1'b0);
      step();
      chk1("sim_no_resume", xbus.xtrig_busy, 1'b0);
      chk4("sim_exit_idle", xbus.xtrig_exit_dbg, 4'b0000);

      // pending halt recorded during resume
      xbus.core_dbgon    = 4'b0111;
      xbus.core_exit_req = 4'b0100;
      step();
      xbus.core_exit_req = '0;
      chk4("pend_exit", xbus.xtrig_exit_dbg, 4'b0110);
      xbus.regs_halt_grp  = 4'b1000;
      xbus.core_enter_req = 4'b1000;
      step();
      xbus.core_enter_req = '0;
      chk4("pend_exit_hold", xbus.xtrig_exit_dbg, 4'b0110);
      chk4("pend_enter_hold", xbus.xtrig_enter_dbg, 4'b0000);
      xbus.core_dbgon = 4'b0001;
      step();
      chk4("pend_exit_done", xbus.xtrig_exit_dbg, 4'b0000);
      chk1("pend_idle", xbus.xtrig_busy, 1'b0);
      step();
      chk4("pend_enter", xbus.xtrig_enter_dbg, 4'b1000);
      chk1("pend_busy", xbus.xtrig_busy, 1'b1);
      xbus.core_dbgon = 4'b1001;
      step();
      chk4("pend_enter_done", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("pend_busy_done", xbus.xtrig_busy, 1'b0);

      // halt with a core that never responds
      xbus.core_dbgon     = 4'b0000;
      xbus.regs_halt_grp  = 4'b0001;
      xbus.core_enter_req = 4'b0001;
      step();
      xbus.core_enter_req = '0;
      chk4("to_enter_c1", xbus.xtrig_enter_dbg, 4'b0001);
      first_to = 0;
      to_cnt   = 0;
      if (xbus.xtrig_timeout === 1'b1) begin
         first_to = 1;
         to_cnt++;
      end
`ifdef CT_HAD_XTRIG_TIMEOUT_EN
      for (int c = 2; c <= 17; c++) begin
         step();
         if (c == 16) chk4("to_enter_c16", xbus.xtrig_enter_dbg, 4'b0001);
         if (xbus.xtrig_timeout === 1'b1) begin
            if (first_to == 0) first_to = c;
            to_cnt++;
         end
      end
      chk4("to_pulse_cycle", 4'(first_to), 4'd0 + 4'(16));
      chk4("to_pulse_count", 4'(to_cnt), 4'd1);
      chk4("to_enter_clr", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("to_busy_clr", xbus.xtrig_busy, 1'b0);
`else
      for (int c = 2; c <= 100; c++) begin
         step();
         if (xbus.xtrig_timeout === 1'b1) to_cnt++;
      end
      chk4("noto_pulse_count", 4'(to_cnt), 4'd0);
      chk4("noto_enter_c100", xbus.xtrig_enter_dbg, 4'b0001);
      chk1("noto_busy_c100", xbus.xtrig_busy, 1'b1);
      xbus.core_dbgon = 4'b0001;
      step();
      chk1("noto_busy_done", xbus.xtrig_busy, 1'b0);
`endif

      // reset in the middle of a halt broadcast
      xbus.core_dbgon     = 4'b0000;
      xbus.regs_halt_grp  = 4'b0011;
      xbus.core_enter_req = 4'b0001;
      step();
      xbus.core_enter_req = '0;
      chk4("rst_mid_enter", xbus.xtrig_enter_dbg, 4'b0011);
      cpurst_b = 1'b0;
      #1;
      chk4("rst_mid_enter_clr", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("rst_mid_busy_clr", xbus.xtrig_busy, 1'b0);
      step();
      cpurst_b = 1'b1;
      step();
      step();
      chk4("rst_after_enter", xbus.xtrig_enter_dbg, 4'b0000);
      chk1("rst_after_busy", xbus.xtrig_busy, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
